ym_bus_writer: RTL and testbench



---
 rtl/ym_bus_writer.sv | 231 +++++++++++++++++++++++
 tb/tb_ym_bus_writer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ym_bus_writer.sv
// Host-side write initiator for the jt03 CPU port: queues (register, value) requests
// and plays each one out as an address write, a data write and the chip's post-write wait.
module ym_bus_writer #(
    parameter int FIFO_DEPTH   = 4,
    parameter int STROBE_CYC   = 2,
    parameter int ADDR_WAIT    = 17,
    parameter int DATA_WAIT    = 83,
    parameter int USE_BUSY     = 1,
    parameter int BUSY_TIMEOUT = 255
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cen,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [7:0]                    req_reg,
    input  logic [7:0]                    req_val,
    output logic [7:0]                    bus_data,
    output logic                          bus_addr,
    output logic                          bus_cs_n,
    output logic                          bus_wr_n,
    input  logic [7:0]                    bus_status,
    output logic                          idle,
    output logic                          timeout_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [7:0]    STROBE_LAST = 8'(STROBE_CYC - 1);
    localparam logic [15:0]   ADDR_LAST   = 16'((ADDR_WAIT > 0) ? ADDR_WAIT - 1 : 0);
    localparam logic [15:0]   DATA_LAST   = 16'((DATA_WAIT > 0) ? DATA_WAIT - 1 : 0);
    localparam logic [15:0]   BUSY_LAST   = 16'((BUSY_TIMEOUT > 0) ? BUSY_TIMEOUT - 1 : 0);
    localparam logic [CW-1:0] FULL_LEVEL  = CW'(FIFO_DEPTH);

    typedef enum logic [3:0] {
        IDLE,
        A_SET,
        A_STB,
        A_HLD,
        A_WAIT,
        D_SET,
        D_STB,
        D_HLD,
        D_WAIT
    } state_t;

    // ------------------------------------------------------------------
    // Request FIFO: {reg, val} per entry
    // ------------------------------------------------------------------
    logic [15:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [15:0]   head_entry;
    logic          fifo_empty;
    logic          push;
    logic          pop;

    state_t        state_reg;
    logic [7:0]    strobe_cnt_reg;
    logic [15:0]   wait_cnt_reg;
    logic          cen_seen_reg;
    logic [7:0]    val_hold_reg;
    logic [7:0]    bus_data_reg;
    logic          bus_addr_reg;
    logic          bus_cs_n_reg;
    logic          bus_wr_n_reg;
    logic          timeout_err_reg;

    // Only the busy flag of the status byte is meaningful here.
    logic          unused_status;
    assign unused_status = ^bus_status[6:0];

    assign fifo_empty = (count_reg == '0);
    assign req_ready  = (count_reg != FULL_LEVEL);
    assign push       = req_valid && req_ready;
    assign pop        = (state_reg == IDLE) && !fifo_empty;
    assign head_entry = fifo_mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {req_reg, req_val};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Bus sequencer; bus outputs change together with the state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            strobe_cnt_reg  <= '0;
            wait_cnt_reg    <= '0;
            cen_seen_reg    <= 1'b0;
            val_hold_reg    <= '0;
            bus_data_reg    <= '0;
            bus_addr_reg    <= 1'b0;
            bus_cs_n_reg    <= 1'b1;
            bus_wr_n_reg    <= 1'b1;
            timeout_err_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pop) begin
                        state_reg    <= A_SET;
                        bus_cs_n_reg <= 1'b0;
                        bus_addr_reg <= 1'b0;
                        bus_data_reg <= head_entry[15:8];
                        val_hold_reg <= head_entry[7:0];
                    end
                end
                A_SET: begin
                    state_reg      <= A_STB;
                    bus_wr_n_reg   <= 1'b0;
                    strobe_cnt_reg <= '0;
                end
                A_STB: begin
                    if (strobe_cnt_reg == STROBE_LAST) begin
                        state_reg    <= A_HLD;
                        bus_wr_n_reg <= 1'b1;
                    end else begin
                        strobe_cnt_reg <= strobe_cnt_reg + 8'd1;
                    end
                end
                A_HLD: begin
                    state_reg    <= A_WAIT;
                    bus_cs_n_reg <= 1'b1;
                    bus_addr_reg <= 1'b0;
                    bus_data_reg <= '0;
                    wait_cnt_reg <= '0;
                end
                A_WAIT: begin
                    if (cen) begin
                        if (wait_cnt_reg == ADDR_LAST) begin
                            state_reg    <= D_SET;
                            bus_cs_n_reg <= 1'b0;
                            bus_addr_reg <= 1'b1;
                            bus_data_reg <= val_hold_reg;
                        end else begin
                            wait_cnt_reg <= wait_cnt_reg + 16'd1;
                        end
                    end
                end
                D_SET: begin
                    state_reg      <= D_STB;
                    bus_wr_n_reg   <= 1'b0;
                    strobe_cnt_reg <= '0;
                end
                D_STB: begin
                    if (strobe_cnt_reg == STROBE_LAST) begin
                        state_reg    <= D_HLD;
                        bus_wr_n_reg <= 1'b1;
                    end else begin
                        strobe_cnt_reg <= strobe_cnt_reg + 8'd1;
                    end
                end
                D_HLD: begin
                    state_reg    <= D_WAIT;
                    bus_cs_n_reg <= 1'b1;
                    bus_addr_reg <= 1'b0;
                    bus_data_reg <= '0;
                    wait_cnt_reg <= '0;
                    cen_seen_reg <= 1'b0;
                end
                D_WAIT: begin
                    if (USE_BUSY == 0) begin
                        if (cen) begin
                            if (wait_cnt_reg == DATA_LAST) begin
                                state_reg <= IDLE;
                            end else begin
                                wait_cnt_reg <= wait_cnt_reg + 16'd1;
                            end
                        end
                    end else if (!cen_seen_reg) begin
                        // The chip raises busy only after it has clocked the write in.
                        if (cen) begin
                            cen_seen_reg <= 1'b1;
                        end
                    end else if (!bus_status[7]) begin
                        state_reg <= IDLE;
                    end else if (cen) begin
                        if (wait_cnt_reg == BUSY_LAST) begin
                            timeout_err_reg <= 1'b1;
                            state_reg       <= IDLE;
                        end else begin
                            wait_cnt_reg <= wait_cnt_reg + 16'd1;
                        end
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    bus_cs_n_reg <= 1'b1;
                    bus_wr_n_reg <= 1'b1;
                    bus_addr_reg <= 1'b0;
                    bus_data_reg <= '0;
                end
            endcase
        end
    end

    assign bus_data    = bus_data_reg;
    assign bus_addr    = bus_addr_reg;
    assign bus_cs_n    = bus_cs_n_reg;
    assign bus_wr_n    = bus_wr_n_reg;
    assign timeout_err = timeout_err_reg;
    assign fifo_level  = count_reg;
    assign idle        = (state_reg == IDLE) && fifo_empty;

endmodule

// File: tb/tb_ym_bus_writer.sv
// Directed bench for ym_bus_writer: one fixed-wait instance and one busy-polling instance
// share clock, reset and cen; bus writes are logged from the wr_n strobes.
module tb_ym_bus_writer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    logic cen   = 1'b1;

    // fixed-wait instance
    logic       f_valid = 1'b0;
    logic       f_ready;
    logic [7:0] f_reg = '0;
    logic [7:0] f_val = '0;
    logic [7:0] f_data;
    logic       f_addr, f_cs_n, f_wr_n;
    logic [7:0] f_status = '0;
    logic       f_idle, f_terr;
    logic [2:0] f_level;

    // busy-polling instance
    logic       b_valid = 1'b0;
    logic       b_ready;
    logic [7:0] b_reg = '0;
    logic [7:0] b_val = '0;
    logic [7:0] b_data;
    logic       b_addr, b_cs_n, b_wr_n;
    logic [7:0] b_status = '0;
    logic       b_idle, b_terr;
    logic [2:0] b_level;

    ym_bus_writer #(.USE_BUSY(0)) u_fix (
        .clk(clk), .rst_n(rst_n), .cen(cen),
        .req_valid(f_valid), .req_ready(f_ready), .req_reg(f_reg), .req_val(f_val),
        .bus_data(f_data), .bus_addr(f_addr), .bus_cs_n(f_cs_n), .bus_wr_n(f_wr_n),
        .bus_status(f_status), .idle(f_idle), .timeout_err(f_terr), .fifo_level(f_level)
    );

    ym_bus_writer #(.USE_BUSY(1)) u_busy (
        .clk(clk), .rst_n(rst_n), .cen(cen),
        .req_valid(b_valid), .req_ready(b_ready), .req_reg(b_reg), .req_val(b_val),
        .bus_data(b_data), .bus_addr(b_addr), .bus_cs_n(b_cs_n), .bus_wr_n(b_wr_n),
        .bus_status(b_status), .idle(b_idle), .timeout_err(b_terr), .fifo_level(b_level)
    );

    int checks = 0;
    int errors = 0;
    int cen_div = 1;
    int cyc = 0;

    // strobe logs: {addr, data} captured when wr_n returns high, plus strobe width
    logic [8:0] f_log[$];
    int         f_wid[$];
    int         f_run = 0;
    logic [8:0] b_log[$];
    int         b_wid[$];
    int         b_run = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            f_run = 0;
        end else if (f_wr_n == 1'b0) begin
            f_run++;
        end else if (f_run != 0) begin
            f_log.push_back({f_addr, f_data});
            f_wid.push_back(f_run);
            f_run = 0;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            b_run = 0;
        end else if (b_wr_n == 1'b0) begin
            b_run++;
        end else if (b_run != 0) begin
            b_log.push_back({b_addr, b_data});
            b_wid.push_back(b_run);
            b_run = 0;
        end
    end

    function automatic logic [8:0] f_log_at(input int i);
        return (i < f_log.size()) ? f_log[i] : 9'h1FF;
    endfunction
    function automatic int f_wid_at(input int i);
        return (i < f_wid.size()) ? f_wid[i] : -1;
    endfunction
    function automatic logic [8:0] b_log_at(input int i);
        return (i < b_log.size()) ? b_log[i] : 9'h1FF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        cen = (cen_div <= 1) ? 1'b1 : ((cyc % cen_div) == 0);
    endtask

    task automatic push_fix(input logic [7:0] r, input logic [7:0] v);
        int w;
        f_reg = r; f_val = v; f_valid = 1'b1;
        w = 0;
        while (!f_ready && w < 1000) begin step(); w++; end
        step();
        f_valid = 1'b0;
    endtask

    task automatic push_busy(input logic [7:0] r, input logic [7:0] v);
        int w;
        b_reg = r; b_val = v; b_valid = 1'b1;
        w = 0;
        while (!b_ready && w < 1000) begin step(); w++; end
        step();
        b_valid = 1'b0;
    endtask

    logic [7:0] t2_reg [5] = '{8'h30, 8'h41, 8'h52, 8'h63, 8'hB4};
    logic [7:0] t2_val [5] = '{8'h01, 8'h7E, 8'h80, 8'hFF, 8'h5A};

    initial begin
        int n, gap, dw, bad;
        bit seen_low, seen_a1;

        // ---------------- reset state ----------------
        repeat (3) step();
        check("rst_cs_n", f_cs_n, 1);
        check("rst_wr_n", f_wr_n, 1);
        check("rst_addr", f_addr, 0);
        check("rst_data", f_data, 0);
        check("rst_level", f_level, 0);
        check("rst_ready", f_ready, 1);
        check("rst_idle", f_idle, 1);
        check("rst_terr", b_terr, 0);
        rst_n = 1'b1;
        step();

        // ---------------- single request, fixed waits ----------------
        f_log.delete(); f_wid.delete();
        f_reg = 8'h28; f_val = 8'hF0; f_valid = 1'b1;
        step();
        f_valid = 1'b0;
        check("t1_level_after_push", f_level, 1);
        check("t1_not_idle", f_idle, 0);
        step();
        n = 1;
        check("t1_aset_cs_n", f_cs_n, 0);
        check("t1_aset_data", f_data, 8'h28);
        check("t1_aset_wr_n", f_wr_n, 1);
        gap = 0; dw = 0; seen_low = 1'b1; seen_a1 = 1'b0;
        while (n < 400 && !f_idle) begin
            step(); n++;
            if (!f_idle) begin
                if (!f_cs_n) begin
                    if (f_addr) seen_a1 = 1'b1;
                end else if (seen_low) begin
                    if (seen_a1) dw++; else gap++;
                end
            end
        end
        check("t1_latency", n - 1, 108);
        check("t1_addr_wait", gap, 17);
        check("t1_data_wait", dw, 83);
        check("t1_nwrites", f_log.size(), 2);
        check("t1_write0", f_log_at(0), 9'h028);
        check("t1_write1", f_log_at(1), 9'h1F0);
        check("t1_strobe0", f_wid_at(0), 2);
        check("t1_strobe1", f_wid_at(1), 2);

        // ---------------- back-to-back pushes, FIFO full ----------------
        f_log.delete(); f_wid.delete();
        for (int k = 0; k < 5; k++) push_fix(t2_reg[k], t2_val[k]);
        check("t2_level_full", f_level, 4);
        check("t2_ready_low", f_ready, 0);
        f_reg = 8'hEE; f_val = 8'hEE; f_valid = 1'b1;
        repeat (3) step();
        f_valid = 1'b0;
        check("t2_full_ignored", f_level, 4);
        n = 0;
        while (n < 800 && !f_idle) begin step(); n++; end
        check("t2_drained", f_idle, 1);
        check("t2_nwrites", f_log.size(), 10);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("t2_reg%0d", k), f_log_at(2 * k), {1'b0, t2_reg[k]});
            check($sformatf("t2_val%0d", k), f_log_at(2 * k + 1), {1'b1, t2_val[k]});
        end

        // ---------------- cen every 4th clk ----------------
        f_log.delete(); f_wid.delete();
        cen_div = 4;
        push_fix(8'h55, 8'hAA);
        n = 0; gap = 0; seen_low = 1'b0; seen_a1 = 1'b0;
        while (n < 1500 && !f_idle) begin
            step(); n++;
            if (!f_idle) begin
                if (!f_cs_n) begin
                    seen_low = 1'b1;
                    if (f_addr) seen_a1 = 1'b1;
                end else if (seen_low && !seen_a1) begin
                    gap++;
                end
            end
        end
        check("t6_done", f_idle, 1);
        check_range("t6_addr_wait", gap, 65, 68);
        check("t6_strobe0", f_wid_at(0), 2);
        check("t6_strobe1", f_wid_at(1), 2);
        check("t6_write1", f_log_at(1), 9'h1AA);
        cen_div = 1;
        step();

        // ---------------- busy polling, busy clears ----------------
        b_log.delete(); b_wid.delete();
        b_status = 8'h80;
        push_busy(8'h10, 8'h11);
        push_busy(8'h20, 8'h22);
        n = 0;
        while (!(b_addr && !b_cs_n) && n < 200) begin step(); n++; end
        check("t3_reach_dset", n < 200, 1);
        while (!b_cs_n && n < 400) begin step(); n++; end
        check("t3_reach_dwait", n < 400, 1);
        repeat (30) step();
        check("t3_still_waiting", b_cs_n, 1);
        check("t3_terr_low", b_terr, 0);
        b_status = 8'h00;
        n = 0;
        while (b_cs_n && n < 10) begin step(); n++; end
        check_range("t3_restart_clks", n, 1, 2);
        check("t3_next_reg", b_data, 8'h20);
        check("t3_next_addr", b_addr, 0);
        check("t3_first_data", b_log_at(1), 9'h111);

        // ---------------- busy stuck, timeout ----------------
        b_status = 8'h80;
        push_busy(8'h30, 8'h33);
        n = 0;
        while (!(b_addr && !b_cs_n) && n < 200) begin step(); n++; end
        while (!b_cs_n && n < 400) begin step(); n++; end
        check("t4_reach_dwait", n < 400, 1);
        n = 0;
        while (!b_terr && n < 400) begin step(); n++; end
        check_range("t4_timeout_cen", n, 255, 257);
        step();
        check("t4_next_cs_n", b_cs_n, 0);
        check("t4_next_reg", b_data, 8'h30);
        b_status = 8'h00;
        n = 0;
        while (!b_idle && n < 400) begin step(); n++; end
        check("t4_drained", b_idle, 1);
        check("t4_sticky", b_terr, 1);
        check("t4_last_write", b_log_at(5), 9'h133);

        // ---------------- reset during data strobe ----------------
        push_fix(8'h77, 8'h66);
        push_fix(8'h78, 8'h67);
        n = 0;
        while (!(f_addr && !f_wr_n) && n < 200) begin step(); n++; end
        check("t5_reach_dstb", f_wr_n, 0);
        check("t5_level_before", f_level, 1);
        rst_n = 1'b0;
        #1;
        check("t5_wr_n", f_wr_n, 1);
        check("t5_cs_n", f_cs_n, 1);
        check("t5_level", f_level, 0);
        check("t5_terr_cleared", b_terr, 0);
        step();
        rst_n = 1'b1;
        bad = 0;
        repeat (150) begin
            step();
            if (!f_idle || !f_cs_n || !f_wr_n || f_data != 8'h00) bad++;
        end
        check("t5_quiet_after", bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
